// File: rtl/mac_pkg.sv
// Shared defaults, accumulator FSM state type and a constant clog2 helper for the MAC PE.
package mac_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAPS   = 3;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 34;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_add_tree.sv
// Registered signed reduction of TAPS products to one ACC_W sum, with valid/last alongside.
module mac_add_tree
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic [TAPS-1:0][2*DATA_W-1:0]  prod,
  output logic signed [ACC_W-1:0]        sum,
  output logic                           sum_valid,
  output logic                           sum_last
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + clog2(TAPS);

  // Full-precision running sum; SUM_W is wide enough that it never overflows.
  logic signed [SUM_W-1:0] partial [TAPS+1];

  assign partial[0] = '0;

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_sum
      assign partial[gi+1] = partial[gi] + SUM_W'($signed(prod[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sum       <= '0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
    end else begin
      sum       <= ACC_W'(partial[TAPS]);
      sum_valid <= in_valid;
      sum_last  <= in_last;
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Pipelined signed MAC processing element: product regs, add tree, accumulator/output stage.
// Optional build macro MAC_SAT_EN: saturate the result to OUT_W instead of truncating.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     w_w,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic                     if_w,
  input  logic signed [DATA_W-1:0] if_in,
  input  logic                     calc,
  input  logic                     last,
  output logic signed [OUT_W-1:0]  out,
  output logic                     out_valid,
  output logic                     busy
);

  logic signed [DATA_W-1:0]      weight  [TAPS];
  logic signed [DATA_W-1:0]      feature [TAPS];
  logic [TAPS-1:0][2*DATA_W-1:0] prod_next;
  logic [TAPS-1:0][2*DATA_W-1:0] prod_reg;
  logic                          s1_valid_reg;
  logic                          s1_last_reg;
  logic signed [ACC_W-1:0]       sum;
  logic                          sum_valid;
  logic                          sum_last;
  logic signed [ACC_W-1:0]       acc_reg;
  logic signed [ACC_W-1:0]       result;
  logic signed [OUT_W-1:0]       narrowed;
  mac_state_t                    state_reg;
  logic                          flush;

  assign flush = rst | clear;

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < TAPS; i++) begin
        weight[i]  <= '0;
        feature[i] <= '0;
      end
    end else begin
      if (w_w) begin
        weight[0] <= w_in;
        for (int i = 1; i < TAPS; i++) weight[i] <= weight[i-1];
      end
      if (if_w) begin
        feature[0] <= if_in;
        for (int i = 1; i < TAPS; i++) feature[i] <= feature[i-1];
      end
    end
  end

  // Operands widened first so the product is formed at full precision.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_prod
      assign prod_next[gi] = (2*DATA_W)'(feature[gi]) * (2*DATA_W)'(weight[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (flush) begin
      prod_reg     <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
    end else begin
      if (calc) prod_reg <= prod_next;
      s1_valid_reg <= calc;
      s1_last_reg  <= calc & last;
    end
  end

  mac_add_tree #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W)
  ) u_add_tree (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (s1_valid_reg),
    .in_last   (s1_last_reg),
    .prod      (prod_reg),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_last  (sum_last)
  );

  // The accumulator is zero in IDLE, so one adder serves both first and later terms.
  assign result = acc_reg + sum;

`ifdef MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    narrowed = result[OUT_W-1:0];
    if (result > SAT_HI)      narrowed = SAT_HI[OUT_W-1:0];
    else if (result < SAT_LO) narrowed = SAT_LO[OUT_W-1:0];
  end
`else
  assign narrowed = result[OUT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sum_valid) begin
        if (sum_last) begin
          out       <= narrowed;
          out_valid <= 1'b1;
          acc_reg   <= '0;
          state_reg <= IDLE;
        end else begin
          acc_reg   <= result;
          state_reg <= ACCUM;
        end
      end
    end
  end

  assign busy = (state_reg == ACCUM) | s1_valid_reg | sum_valid;

endmodule
